// File: rtl/mem_stage_if.sv
// Bus bundle between EX, the data SRAM read port, MEM, WB and the ID forwarding path.
// The master side drives the EX bus and SRAM data; mem_stage is the slave.
interface mem_stage_if #(
    parameter int EX_TO_MEM_WD = 79,
    parameter int MEM_TO_WB_WD = 70
);
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [31:0]             data_sram_rdata;
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
    logic [37:0]             mem_to_id_bus;

    modport master (
        output ex_to_mem_bus,
        output data_sram_rdata,
        input  mem_to_wb_bus,
        input  mem_to_id_bus
    );

    modport slave (
        input  ex_to_mem_bus,
        input  data_sram_rdata,
        output mem_to_wb_bus,
        output mem_to_id_bus
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX bus, aligns/extends load data from the SRAM,
// and keeps the SRAM word of a stalled load so it survives the data changing underneath.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 79,
    parameter int MEM_TO_WB_WD = 70
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    mem_stage_if.slave  bus
);

    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_BU = 3'b010,
        LD_H  = 3'b011,
        LD_HU = 3'b100
    } ld_op_e;

    logic [EX_TO_MEM_WD-1:0] ex_reg;
    logic                    hold_valid;
    logic [31:0]             hold_data;

    logic        stall_ex;
    logic        stall_mem;
    logic        do_bubble;
    logic        do_load;

    assign stall_ex  = stall[3];
    assign stall_mem = stall[4];
    assign do_bubble = stall_ex && !stall_mem;
    assign do_load   = !stall_ex;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_reg     <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (do_bubble) begin
            ex_reg     <= '0;
            hold_valid <= 1'b0;
        end else if (do_load) begin
            ex_reg     <= bus.ex_to_mem_bus;
            hold_valid <= 1'b0;
        end else if (!hold_valid) begin
            // First held cycle: the SRAM word for this load is still on the port.
            hold_data  <= bus.data_sram_rdata;
            hold_valid <= 1'b1;
        end
    end

    logic [31:0] mem_pc;
    logic [2:0]  ld_op;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;

    assign mem_pc       = ex_reg[78:47];
    assign data_ram_en  = ex_reg[46];
    assign data_ram_wen = ex_reg[45:42];
    assign ld_op        = ex_reg[41:39];
    assign sel_rf_res   = ex_reg[38];
    assign rf_we        = ex_reg[37];
    assign rf_waddr     = ex_reg[36:32];
    assign ex_result    = ex_reg[31:0];

    logic [31:0] load_src;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;

    assign load_src  = hold_valid ? hold_data : bus.data_sram_rdata;
    assign load_half = ex_result[1] ? load_src[31:16] : load_src[15:0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        load_byte = load_src[7:0];
        case (ex_result[1:0])
            2'b01:   load_byte = load_src[15:8];
            2'b10:   load_byte = load_src[23:16];
            2'b11:   load_byte = load_src[31:24];
            default: load_byte = load_src[7:0];
        endcase
    end

    always_comb begin
        load_data = load_src;
        case (ld_op_e'(ld_op))
            LD_B:    load_data = {{24{load_byte[7]}}, load_byte};
            LD_BU:   load_data = {24'd0, load_byte};
            LD_H:    load_data = {{16{load_half[15]}}, load_half};
            LD_HU:   load_data = {16'd0, load_half};
            default: load_data = load_src;
        endcase
    end

    assign rf_wdata          = sel_rf_res ? load_data : ex_result;
    assign bus.mem_to_wb_bus = {mem_pc, rf_we, rf_waddr, rf_wdata};
    assign bus.mem_to_id_bus = bus.mem_to_wb_bus[37:0];

    // Store controls ride along for debug visibility only; the other stall bits belong to other stages.
    logic unused_ctl;
    assign unused_ctl = ^{data_ram_en, data_ram_wen, stall[5], stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load/stall/reset scenarios followed by
// randomized traffic, all compared against a behavioural model of the stage.
module tb_mem_stage;

    logic       clk;
    logic       rst;
    logic [5:0] stall;

    mem_stage_if #(.EX_TO_MEM_WD(79), .MEM_TO_WB_WD(70)) bus ();

    mem_stage #(.EX_TO_MEM_WD(79), .MEM_TO_WB_WD(70)) dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: the instruction sitting in MEM, and the saved SRAM word if any.
    logic [78:0] m_ex;
    logic        m_held;
    logic [31:0] m_word;
    logic [31:0] cur_rdata;

    function automatic logic [78:0] mk(input logic [31:0] pc, input logic [2:0] ld,
                                       input logic sel, input logic we,
                                       input logic [4:0] wa, input logic [31:0] res);
        mk = {pc, 1'b1, 4'b0000, ld, sel, we, wa, res};
    endfunction

    function automatic logic [31:0] sext8(input int unsigned v);
        sext8 = (v >= 128) ? 32'(v) - 32'd256 : 32'(v);
    endfunction

    function automatic logic [31:0] sext16(input int unsigned v);
        sext16 = (v >= 32768) ? 32'(v) - 32'd65536 : 32'(v);
    endfunction

    // Expected writeback bus from the architectural meaning of the instruction.
    function automatic logic [69:0] expect_wb(input logic [78:0] e, input logic [31:0] word);
        int unsigned a, w, b, h;
        logic [31:0] val;
        a = 32'(e[1:0]);
        w = word;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (e[41:39])
            3'd1:    val = sext8(b);
            3'd2:    val = b;
            3'd3:    val = sext16(h);
            3'd4:    val = h;
            default: val = word;
        endcase
        if (!e[38]) val = e[31:0];
        expect_wb = {e[78:47], e[37], e[36:32], val};
    endfunction

    task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: present inputs, advance the model at the edge, then present the SRAM data
    // for the instruction now in MEM and compare all outputs.
    task automatic step(input logic [78:0] ex, input logic [5:0] st,
                        input logic [31:0] rd, input logic r);
        bus.ex_to_mem_bus = ex;
        stall = st;
        rst = r;
        @(posedge clk);
        if (r) begin
            m_ex = '0; m_held = 1'b0; m_word = '0;
        end else if (st[3] && !st[4]) begin
            m_ex = '0; m_held = 1'b0;
        end else if (!st[3]) begin
            m_ex = ex; m_held = 1'b0;
        end else if (!m_held) begin
            m_word = cur_rdata; m_held = 1'b1;
        end
        #1;
        bus.data_sram_rdata = rd;
        cur_rdata = rd;
        #1;
        check("wb_bus", bus.mem_to_wb_bus, expect_wb(m_ex, m_held ? m_word : cur_rdata));
        check("id_bus", 70'(bus.mem_to_id_bus), 70'(bus.mem_to_wb_bus[37:0]));
        check("hold_valid", 70'(dut.hold_valid), 70'(m_held));
    endtask

    initial begin
        logic [78:0] rex;
        logic [5:0]  rst_v;
        int          pick;

        m_ex = '0; m_held = 1'b0; m_word = '0; cur_rdata = '0;
        bus.ex_to_mem_bus = '0;
        bus.data_sram_rdata = '0;
        stall = '0;
        rst = 1'b1;

        // Reset with random inputs and an active stall still yields all-zero buses.
        step(mk(32'hBFC0_0000, 3'd0, 1'b1, 1'b1, 5'd9, 32'h1234_5678), 6'b011000, 32'hFFFF_FFFF, 1'b1);
        check("rst_wb_zero", bus.mem_to_wb_bus, 70'd0);
        check("rst_id_zero", 70'(bus.mem_to_id_bus), 70'd0);

        // Load alignment and extension.
        step(mk(32'h100, 3'd2, 1'b1, 1'b1, 5'd5, 32'h1003), 6'b0, 32'h80FF_1234, 1'b0);
        check("lbu_data", 70'(bus.mem_to_wb_bus[37:0]), {1'b1, 5'd5, 32'h0000_0080});
        step(mk(32'h104, 3'd1, 1'b1, 1'b1, 5'd5, 32'h1003), 6'b0, 32'h80FF_1234, 1'b0);
        check("lb_data", 70'(bus.mem_to_wb_bus[31:0]), 70'h0_FFFF_FF80);
        step(mk(32'h108, 3'd3, 1'b1, 1'b1, 5'd6, 32'h1002), 6'b0, 32'h80FF_1234, 1'b0);
        check("lh_data", 70'(bus.mem_to_wb_bus[31:0]), 70'h0_FFFF_80FF);
        step(mk(32'h10C, 3'd4, 1'b1, 1'b1, 5'd7, 32'h1000), 6'b0, 32'h80FF_1234, 1'b0);
        check("lhu_data", 70'(bus.mem_to_wb_bus[31:0]), 70'h0_0000_1234);
        step(mk(32'h110, 3'd3, 1'b1, 1'b1, 5'd7, 32'h1001), 6'b0, 32'h80FF_1234, 1'b0);
        check("lh_odd_addr", 70'(bus.mem_to_wb_bus[31:0]), 70'h0_0000_1234);
        step(mk(32'h114, 3'd7, 1'b1, 1'b1, 5'd8, 32'h1003), 6'b0, 32'h80FF_1234, 1'b0);
        check("ldop7_as_lw", 70'(bus.mem_to_wb_bus[31:0]), 70'h0_80FF_1234);

        // ALU result passes through and the forwarding bus mirrors it.
        step(mk(32'h118, 3'd1, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF), 6'b0, 32'h0, 1'b0);
        check("alu_data", bus.mem_to_wb_bus, {32'h118, 1'b1, 5'd3, 32'hDEAD_BEEF});

        // Stalled load keeps its original word while SRAM data moves on.
        step(mk(32'h200, 3'd0, 1'b1, 1'b1, 5'd10, 32'h2000), 6'b0, 32'h1111_1111, 1'b0);
        check("lw_data", 70'(bus.mem_to_wb_bus[31:0]), 70'h0_1111_1111);
        for (int i = 0; i < 3; i++) begin
            step(mk(32'h204, 3'd0, 1'b1, 1'b1, 5'd11, 32'h2004), 6'b011000, 32'h2222_2222, 1'b0);
            check("lw_held", 70'(bus.mem_to_wb_bus[31:0]), 70'h0_1111_1111);
        end
        step(mk(32'h204, 3'd0, 1'b1, 1'b1, 5'd11, 32'h2004), 6'b0, 32'h3333_3333, 1'b0);
        check("after_release", bus.mem_to_wb_bus, {32'h204, 1'b1, 5'd11, 32'h3333_3333});

        // EX stopped with MEM running inserts a bubble.
        step(mk(32'h208, 3'd0, 1'b1, 1'b1, 5'd12, 32'h2008), 6'b001000, 32'h4444_4444, 1'b0);
        check("bubble", bus.mem_to_wb_bus, 70'd0);

        // Reset in the middle of a held load leaves nothing behind.
        step(mk(32'h300, 3'd0, 1'b1, 1'b1, 5'd13, 32'h3000), 6'b0, 32'h5555_5555, 1'b0);
        step(mk(32'h304, 3'd0, 1'b1, 1'b1, 5'd14, 32'h3004), 6'b011000, 32'h6666_6666, 1'b0);
        check("held_before_rst", 70'(bus.mem_to_wb_bus[31:0]), 70'h0_5555_5555);
        step(mk(32'h304, 3'd0, 1'b1, 1'b1, 5'd14, 32'h3004), 6'b011000, 32'h7777_7777, 1'b1);
        check("rst_mid_hold_wb", bus.mem_to_wb_bus, 70'd0);
        check("rst_mid_hold_id", 70'(bus.mem_to_id_bus), 70'd0);
        check("rst_mid_hold_hv", 70'(dut.hold_valid), 70'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rex = {$urandom, 1'($urandom), 4'($urandom), 3'($urandom), 1'($urandom),
                   1'($urandom), 5'($urandom), $urandom};
            pick = $urandom_range(0, 7);
            if (pick < 4)       rst_v = 6'b000000;
            else if (pick < 6)  rst_v = 6'b011000;
            else if (pick == 6) rst_v = 6'b001000;
            else                rst_v = 6'($urandom);
            step(rex, rst_v, $urandom, ($urandom_range(0, 31) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
